// File: rtl/terminal_pkg.sv
// Shared text-terminal definitions: screen geometry, cell layout and SDRAM cell addressing.
// Used by the row reader and the terminal stream writer.
package terminal_pkg;

  localparam int unsigned COLUMNS = 80;
  localparam int unsigned ROWS    = 51;
  localparam int unsigned ADDR_W  = 23;
  localparam int unsigned CELL_W  = 32;
  localparam int unsigned COL_W   = 7;
  localparam int unsigned ROW_W   = 6;

  // Cell field bit positions
  localparam int unsigned ORD_LSB       = 0;
  localparam int unsigned ORD_MSB       = 9;
  localparam int unsigned SIZE_LSB      = 10;
  localparam int unsigned SIZE_MSB      = 11;
  localparam int unsigned PART_LSB      = 12;
  localparam int unsigned PART_MSB      = 13;
  localparam int unsigned BLINK_LSB     = 14;
  localparam int unsigned BLINK_MSB     = 15;
  localparam int unsigned INVERT_BIT    = 16;
  localparam int unsigned UNDERLINE_BIT = 17;
  localparam int unsigned FUNC_LSB      = 18;
  localparam int unsigned FUNC_MSB      = 19;
  localparam int unsigned PATTERN_LSB   = 20;
  localparam int unsigned PATTERN_MSB   = 23;
  localparam int unsigned FG_LSB        = 24;
  localparam int unsigned FG_MSB        = 27;
  localparam int unsigned BG_LSB        = 28;
  localparam int unsigned BG_MSB        = 31;

  localparam logic [1:0] SIZE_NORMAL = 2'd0;
  localparam logic [1:0] SIZE_WIDE   = 2'd1;
  localparam logic [1:0] SIZE_TALL   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  localparam logic [1:0] PART_TOP_LEFT     = 2'd0;
  localparam logic [1:0] PART_TOP_RIGHT    = 2'd1;
  localparam logic [1:0] PART_BOTTOM_LEFT  = 2'd2;
  localparam logic [1:0] PART_BOTTOM_RIGHT = 2'd3;

  localparam logic [1:0] BLINK_OFF  = 2'd0;
  localparam logic [1:0] BLINK_SLOW = 2'd1;
  localparam logic [1:0] BLINK_FAST = 2'd2;

  localparam logic [1:0] LOGICAL_SET = 2'd0;
  localparam logic [1:0] LOGICAL_OR  = 2'd1;
  localparam logic [1:0] LOGICAL_AND = 2'd2;
  localparam logic [1:0] LOGICAL_XOR = 2'd3;

  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [3:0] pattern;
    logic [1:0] func;
    logic       underline;
    logic       invert;
    logic [1:0] blink;
    logic [1:0] part;
    logic [1:0] size;
    logic [9:0] ord;
  } cell_t;

  // Space, fg 15, bg 0, OR function, normal size
  localparam logic [CELL_W-1:0] CLEAR_CELL = 32'h0F04_0020;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] cell_address(input int unsigned x,
                                                      input int unsigned y,
                                                      input int unsigned cols = COLUMNS);
    return ADDR_W'(4 * (y * cols + x));
  endfunction

  localparam logic [ADDR_W-1:0] LAST_ADDRESS = cell_address(COLUMNS - 1, ROWS - 1);

endpackage

// File: rtl/text_row_reader_if.sv
// SDRAM read port used by the text row reader (master) and the memory controller (slave).
interface text_row_reader_if;
  import terminal_pkg::*;

  logic [ADDR_W-1:0] rd_address;
  logic              rd_request;
  logic [CELL_W-1:0] rd_data;
  logic              rd_done;

  modport master (output rd_address, output rd_request, input rd_data, input rd_done);
  modport slave  (input rd_address, input rd_request, output rd_data, output rd_done);
endinterface

// File: rtl/text_row_reader_line_buffer_ram.sv
// Two-bank line buffer: one write port for the fetch FSM, one registered read port for the renderer.
// Columns at or beyond COLUMNS read back as zero.
module line_buffer_ram
  import terminal_pkg::*;
#(
  parameter int unsigned COLUMNS = terminal_pkg::COLUMNS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [COL_W-1:0] wr_col,
  input  cell_t            wr_data,
  input  logic             rd_bank,
  input  logic [COL_W-1:0] rd_col,
  output cell_t            rd_data
);

  localparam int unsigned DEPTH = 2 * COLUMNS;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  cell_t             mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  cell_t             rd_data_d;
  cell_t             rd_data_q;

  always_comb begin
    wr_idx    = IDX_W'(32'(wr_bank) * COLUMNS + 32'(wr_col));
    rd_idx    = IDX_W'(32'(rd_bank) * COLUMNS + 32'(rd_col));
    rd_data_d = '0;
    if (32'(rd_col) < COLUMNS) rd_data_d = mem[rd_idx];
  end

  // Contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/text_row_reader.sv
// Fetches one text row from SDRAM into the back half of a double-buffered line buffer.
// Optional CELL_BLANK_ON_UNDERRUN_EN: show clear cells after an underrun until the next completed fetch.
module text_row_reader
  import terminal_pkg::*;
#(
  parameter int unsigned COLUMNS = terminal_pkg::COLUMNS,
  parameter int unsigned ROWS    = terminal_pkg::ROWS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic [ROW_W-1:0]   fetch_row,
  output logic               fetch_busy,
  output logic               fetch_done,
  input  logic               swap,
  output logic               underrun,
  input  logic [COL_W-1:0]   cell_index,
  output cell_t              cell_out,
  text_row_reader_if.master  rd
);

  state_e            state_q, state_d;
  logic              front_q, front_d;
  logic              target_q, target_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] rd_address_q, rd_address_d;
  logic              rd_request_q, rd_request_d;
  logic              fetch_busy_q, fetch_busy_d;
  logic              fetch_done_q, fetch_done_d;
  logic              underrun_q, underrun_d;
`ifdef CELL_BLANK_ON_UNDERRUN_EN
  logic              blank_q, blank_d;
`endif

  logic              wr_en;
  logic              last_store;
  int unsigned       row_sel;
  cell_t             ram_rdata;

  always_comb begin
    state_d      = state_q;
    front_d      = front_q ^ swap;
    target_d     = target_q;
    base_d       = base_q;
    col_d        = col_q;
    rd_address_d = rd_address_q;
    rd_request_d = 1'b0;
    fetch_busy_d = fetch_busy_q;
    fetch_done_d = 1'b0;
    underrun_d   = underrun_q;
`ifdef CELL_BLANK_ON_UNDERRUN_EN
    blank_d      = blank_q;
`endif
    wr_en        = 1'b0;
    last_store   = (state_q == ST_WAIT) && rd.rd_done && (col_q == COL_W'(COLUMNS - 1));
    row_sel      = (32'(fetch_row) >= ROWS) ? 32'd0 : 32'(fetch_row);

    // A swap that lands on the completing store is not an underrun
    if (swap && fetch_busy_q && !last_store) begin
      underrun_d = 1'b1;
`ifdef CELL_BLANK_ON_UNDERRUN_EN
      blank_d    = 1'b1;
`endif
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          target_d     = ~front_d;
          base_d       = cell_address(0, row_sel, COLUMNS);
          col_d        = '0;
          fetch_busy_d = 1'b1;
          state_d      = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        rd_address_d = base_q + ADDR_W'({col_q, 2'b00});
        rd_request_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd.rd_done) begin
          wr_en = 1'b1;
          if (last_store) begin
            fetch_busy_d = 1'b0;
            fetch_done_d = 1'b1;
`ifdef CELL_BLANK_ON_UNDERRUN_EN
            blank_d      = 1'b0;
`endif
            state_d      = ST_IDLE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = ST_REQUEST;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      front_q      <= 1'b0;
      target_q     <= 1'b0;
      base_q       <= '0;
      col_q        <= '0;
      rd_address_q <= '0;
      rd_request_q <= 1'b0;
      fetch_busy_q <= 1'b0;
      fetch_done_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef CELL_BLANK_ON_UNDERRUN_EN
      blank_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      target_q     <= target_d;
      base_q       <= base_d;
      col_q        <= col_d;
      rd_address_q <= rd_address_d;
      rd_request_q <= rd_request_d;
      fetch_busy_q <= fetch_busy_d;
      fetch_done_q <= fetch_done_d;
      underrun_q   <= underrun_d;
`ifdef CELL_BLANK_ON_UNDERRUN_EN
      blank_q      <= blank_d;
`endif
    end
  end

  line_buffer_ram #(.COLUMNS(COLUMNS)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_bank (target_q),
    .wr_col  (col_q),
    .wr_data (cell_t'(rd.rd_data)),
    .rd_bank (front_q),
    .rd_col  (cell_index),
    .rd_data (ram_rdata)
  );

  assign rd.rd_address = rd_address_q;
  assign rd.rd_request = rd_request_q;
  assign fetch_busy    = fetch_busy_q;
  assign fetch_done    = fetch_done_q;
  assign underrun      = underrun_q;

`ifdef CELL_BLANK_ON_UNDERRUN_EN
  assign cell_out = blank_q ? cell_t'(CLEAR_CELL) : ram_rdata;
`else
  assign cell_out = ram_rdata;
`endif

endmodule

// File: tb/tb_text_row_reader.sv
// Directed bench for text_row_reader: SDRAM responder echoing the address as data after 3 cycles.
module tb_text_row_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fetch_start;
  logic [5:0]  fetch_row;
  logic        fetch_busy;
  logic        fetch_done;
  logic        swap;
  logic        underrun;
  logic [6:0]  cell_index;
  logic [31:0] cell_out;

  text_row_reader_if rd_if ();

  logic        resp_done = 1'b0;
  logic [31:0] resp_data = '0;
  logic        man_done  = 1'b0;
  logic [31:0] man_data  = '0;
  assign rd_if.rd_done = resp_done | man_done;
  assign rd_if.rd_data = man_done ? man_data : resp_data;

  text_row_reader dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_start (fetch_start),
    .fetch_row   (fetch_row),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .swap        (swap),
    .underrun    (underrun),
    .cell_index  (cell_index),
    .cell_out    (cell_out),
    .rd          (rd_if)
  );

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          resp_cnt  = 0;
  int          done_cnt  = 0;
  logic [22:0] req_log[$];

  // Responder: log every request, answer with data = address three cycles later
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = 1'b1;
    end
    if (rd_if.rd_request) begin
      req_log.push_back(rd_if.rd_address);
      resp_cnt  = 3;
      resp_data = 32'(rd_if.rd_address);
    end
    if (fetch_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    else pass_cnt++;
  endtask

  task automatic pulse_start(input int unsigned row);
    @(negedge clk);
    fetch_row   = 6'(row);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
  endtask

  task automatic pulse_swap();
    @(negedge clk);
    swap = 1'b1;
    @(negedge clk);
    swap = 1'b0;
  endtask

  task automatic wait_done(input bit swap_at_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (fetch_done) begin
        ok = 1'b1;
        if (swap_at_done) swap = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    swap = 1'b0;
  endtask

  task automatic read_cell(input string name, input logic [6:0] idx, input logic [31:0] exp);
    @(negedge clk);
    cell_index = idx;
    @(negedge clk);
    check(name, cell_out, exp);
  endtask

  task automatic verify_log(input string name, input logic [22:0] first, input logic [22:0] last);
    int bad = 0;
    foreach (req_log[i]) if (req_log[i] !== first + 23'(4 * i)) bad++;
    check({name, "_count"}, 32'(req_log.size()), 32'd80);
    check({name, "_first"}, (req_log.size() > 0) ? 32'(req_log[0]) : 32'hFFFF_FFFF, 32'(first));
    check({name, "_last"}, (req_log.size() > 0) ? 32'(req_log[$]) : 32'hFFFF_FFFF, 32'(last));
    check({name, "_steps"}, 32'(bad), 32'd0);
  endtask

  task automatic do_fetch(input string name, input int unsigned row, input bit swap_at_done,
                          input logic [22:0] first, input logic [22:0] last);
    int snap;
    bit ok;
    snap = done_cnt;
    req_log.delete();
    pulse_start(row);
    wait_done(swap_at_done, ok);
    check({name, "_done_seen"}, 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    verify_log(name, first, last);
    check({name, "_done_pulses"}, 32'(done_cnt - snap), 32'd1);
    check({name, "_busy_after"}, 32'(fetch_busy), 32'd0);
  endtask

  typedef struct {
    string       name;
    int unsigned row;
    logic [22:0] first;
    logic [22:0] last;
  } fetch_vec_t;

  typedef struct {
    logic [6:0]  idx;
    logic [31:0] exp;
  } read_vec_t;

  fetch_vec_t fv[4];
  read_vec_t  rv[5];

  initial begin
    bit ok;
    int snap;
    logic [31:0] blank_exp;

    fv[0] = '{"row50", 50, 23'd16000, 23'd16316};
    fv[1] = '{"row51", 51, 23'd0,     23'd316};
    fv[2] = '{"row0",  0,  23'd0,     23'd316};
    fv[3] = '{"row2",  2,  23'd640,   23'd956};
    rv[0] = '{7'd5,   32'd660};
    rv[1] = '{7'd0,   32'd640};
    rv[2] = '{7'd79,  32'd956};
    rv[3] = '{7'd80,  32'd0};
    rv[4] = '{7'd127, 32'd0};

    reset = 1'b1; fetch_start = 1'b0; swap = 1'b0; fetch_row = '0; cell_index = 7'd100;
    repeat (3) @(negedge clk);
    check("rst_rd_request", 32'(rd_if.rd_request), 32'd0);
    check("rst_rd_address", 32'(rd_if.rd_address), 32'd0);
    check("rst_fetch_busy", 32'(fetch_busy), 32'd0);
    check("rst_fetch_done", 32'(fetch_done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_cell_out", cell_out, 32'd0);
    reset = 1'b0;

    // Stray completions while idle must be ignored
    repeat (2) @(negedge clk);
    man_data = 32'hDEAD_BEEF;
    man_done = 1'b1;
    @(negedge clk) man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk) man_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(fetch_busy), 32'd0);
    check("idle_requests", 32'(req_log.size()), 32'd0);
    check("idle_done", 32'(done_cnt), 32'd0);
    check("idle_cell_oob", cell_out, 32'd0);

    // Table of row fetches, all into bank 1 while front is bank 0
    for (int i = 0; i < 4; i++) do_fetch(fv[i].name, fv[i].row, 1'b0, fv[i].first, fv[i].last);
    check("no_underrun_idle_fetches", 32'(underrun), 32'd0);

    pulse_swap();
    for (int i = 0; i < 5; i++) read_cell($sformatf("read_idx%0d", rv[i].idx), rv[i].idx, rv[i].exp);

    // Restart attempt mid-fetch: row 7 request must be ignored
    snap = done_cnt;
    req_log.delete();
    pulse_start(2);
    repeat (20) @(negedge clk);
    check("restart_busy_mid", 32'(fetch_busy), 32'd1);
    pulse_start(7);
    wait_done(1'b0, ok);
    check("restart_done_seen", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    verify_log("restart", 23'd640, 23'd956);
    check("restart_done_pulses", 32'(done_cnt - snap), 32'd1);

    // Swap coinciding with fetch_done: honoured, no underrun
    do_fetch("swapdone", 5, 1'b1, 23'd1600, 23'd1916);
    check("swapdone_underrun", 32'(underrun), 32'd0);
    read_cell("swapdone_cell1", 7'd1, 32'd1604);

    // Swap and fetch_start together: fetch goes to the post-swap back buffer
    snap = done_cnt;
    req_log.delete();
    @(negedge clk);
    fetch_row = 6'd4; fetch_start = 1'b1; swap = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0; swap = 1'b0;
    wait_done(1'b0, ok);
    check("swapstart_done_seen", 32'(ok), 32'd1);
    check("swapstart_underrun", 32'(underrun), 32'd0);
    read_cell("swapstart_front_kept", 7'd0, 32'd640);
    pulse_swap();
    read_cell("swapstart_back_filled", 7'd0, 32'd1280);

    // Swap during a fetch: sticky underrun, optional blanking until fetch_done
    req_log.delete();
    cell_index = 7'd5;
    pulse_start(3);
    for (int i = 0; i < 3000 && req_log.size() < 12; i++) @(negedge clk);
    check("underrun_progress", 32'(req_log.size() >= 12), 32'd1);
    pulse_swap();
    @(negedge clk);
`ifdef CELL_BLANK_ON_UNDERRUN_EN
    blank_exp = 32'h0F04_0020;
`else
    blank_exp = 32'd980;
`endif
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_cell_during", cell_out, blank_exp);
    check("underrun_busy_continues", 32'(fetch_busy), 32'd1);
    wait_done(1'b0, ok);
    check("underrun_done_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("underrun_sticky", 32'(underrun), 32'd1);
    check("underrun_fetch_count", 32'(req_log.size()), 32'd80);
    read_cell("underrun_cell_after5", 7'd5, 32'd980);
    read_cell("underrun_cell_after79", 7'd79, 32'd1276);

    // Reset in the middle of a fetch, with a completion still in flight
    snap = done_cnt;
    req_log.delete();
    pulse_start(6);
    for (int i = 0; i < 3000 && req_log.size() < 11; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midreset_busy", 32'(fetch_busy), 32'd0);
    check("midreset_no_done", 32'(done_cnt - snap), 32'd0);
    check("midreset_no_new_req", 32'(req_log.size()), 32'd11);
    check("midreset_request", 32'(rd_if.rd_request), 32'd0);
    check("midreset_underrun", 32'(underrun), 32'd0);
    do_fetch("row1_after_reset", 1, 1'b0, 23'd320, 23'd636);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
